// File: rtl/keypad_pkg.sv
// Shared constants and helpers for the 4x4 matrix keypad scanner.
// Key index convention: bit (4*row + col) of a key map.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  localparam logic [3:0] KEY_LAYOUT [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  function automatic logic [3:0] encode_key(input logic [3:0] index);
    return KEY_LAYOUT[index];
  endfunction

  function automatic logic [4:0] popcount16(input logic [15:0] value);
    logic [4:0] count;
    count = '0;
    for (int i = 0; i < 16; i++) count = count + {4'd0, value[i]};
    return count;
  endfunction

  function automatic logic [3:0] lowest_set16(input logic [15:0] value);
    logic [3:0] index;
    index = '0;
    for (int i = 15; i >= 0; i--) begin
      if (value[i]) index = 4'(i);
    end
    return index;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs (keypad rows, switches, buttons).
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, per-scan snapshot debounce, single-press events.
// state   | meaning
// ST_IDLE | reset / first cycle, all columns released (col_out = 1111)
// ST_SCAN | one column driven low, period timer counting down to the sample cycle
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_PERIOD    = 100_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [15:0] keys_out,
  output logic        key_valid_out,
  output logic [3:0]  key_code_out,
  output logic        key_held_out
);

  localparam int PW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [PW-1:0] PERIOD_LOAD = PW'(SCAN_PERIOD - 1);
  localparam logic [CW-1:0] STABLE_DONE = CW'(DEBOUNCE_SCANS);
  localparam logic [1:0]    LAST_COL    = 2'(NUM_COLS - 1);

  scan_state_e r_state;
  scan_state_e w_state_next;

  logic [PW-1:0] r_period;
  logic [1:0]    r_col_idx;
  logic [15:0]   r_snap;
  logic [15:0]   r_last;
  logic [CW-1:0] r_stable;
  logic [15:0]   r_keys;
  logic [15:0]   r_keys_d;
  logic          r_valid;
  logic [3:0]    r_code;
  logic          r_held;

  logic [3:0]  w_row_sync;
  logic [3:0]  w_col_out;
  logic        w_sample;
  logic        w_scan_done;
  logic [15:0] w_snap_next;
  logic        w_new_press;

  // Rows idle high (pulled up), so the synchronizer resets to "no key".
  sync_2ff #(
    .WIDTH   (NUM_ROWS),
    .RST_VAL ({NUM_ROWS{1'b1}})
  ) u_row_sync (
    .i_clk (clk_in),
    .i_rst (rst_in),
    .i_d   (row_in),
    .o_q   (w_row_sync)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_col_out    = 4'b1111;
    w_sample     = 1'b0;
    case (r_state)
      ST_IDLE: w_state_next = ST_SCAN;
      ST_SCAN: begin
        w_col_out = ~(4'b0001 << r_col_idx);
        w_sample  = (r_period == '0);
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_scan_done = w_sample && (r_col_idx == LAST_COL);

  always_comb begin
    w_snap_next = r_snap;
    for (int r = 0; r < NUM_ROWS; r++) begin
      w_snap_next[{2'(r), r_col_idx}] = ~w_row_sync[r];
    end
  end

  // Down-counting period timer; reload on the sample (terminal) cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_period  <= '0;
      r_col_idx <= '0;
      r_snap    <= '0;
    end else if (r_state == ST_IDLE || w_sample) begin
      r_period <= PERIOD_LOAD;
      if (w_sample) begin
        r_col_idx <= r_col_idx + 2'd1;
        r_snap    <= w_snap_next;
      end
    end else begin
      r_period <= r_period - 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_last   <= '0;
      r_stable <= '0;
      r_keys   <= '0;
    end else if (w_scan_done) begin
      if (w_snap_next != r_last) begin
        r_last   <= w_snap_next;
        r_stable <= '0;
      end else if (r_stable < STABLE_DONE) begin
        r_stable <= r_stable + 1'b1;
        if (r_stable == STABLE_DONE - 1'b1) r_keys <= r_last;
      end
    end
  end

  // Only an idle-to-single-key transition counts as a new press.
  assign w_new_press = (popcount16(r_keys) == 5'd1) && (popcount16(r_keys_d) == 5'd0);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_keys_d <= '0;
      r_valid  <= 1'b0;
      r_code   <= '0;
      r_held   <= 1'b0;
    end else begin
      r_keys_d <= r_keys;
      r_valid  <= w_new_press;
      r_held   <= (popcount16(r_keys) == 5'd1);
      if (w_new_press) r_code <= encode_key(lowest_set16(r_keys));
    end
  end

  assign col_out       = w_col_out;
  assign keys_out      = r_keys;
  assign key_valid_out = r_valid;
  assign key_code_out  = r_code;
  assign key_held_out  = r_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: scan-aligned key patterns against a snapshot-history model.
module tb_keypad_scanner;

  localparam int SP       = 4;
  localparam int DS       = 2;
  localparam int SCAN_CYC = 4 * SP;
  localparam int NV       = 13;

  typedef struct {
    logic [15:0] press;
    int          scans;
    logic [15:0] keys;
    logic [3:0]  code;
    logic        held;
    int          pulses;
  } vec_t;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] keys_out;
  logic        key_valid_out;
  logic [3:0]  key_code_out;
  logic        key_held_out;

  logic [15:0] pressed = '0;
  int          checks = 0;
  int          failures = 0;
  int          pulse_cnt = 0;
  logic        prev_valid = 1'b0;
  int          row_sel = 0;
  vec_t        vecs [NV];

  logic [15:0] hist [$];
  logic [15:0] m_keys = '0;
  logic [3:0]  m_code = '0;
  logic        m_held = 1'b0;
  int          m_pulses = 0;

  keypad_scanner #(
    .SCAN_PERIOD    (SP),
    .DEBOUNCE_SCANS (DS)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .row_in        (row_in),
    .col_out       (col_out),
    .keys_out      (keys_out),
    .key_valid_out (key_valid_out),
    .key_code_out  (key_code_out),
    .key_held_out  (key_held_out)
  );

  always #5 clk_in = ~clk_in;

  // Physical matrix: a pressed key pulls its row low while its column is driven low.
  function automatic logic [3:0] rows_for(input logic [15:0] p, input logic [3:0] cols);
    logic [3:0] rows;
    logic [3:0] k;
    rows = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      k = 4'(i);
      if (p[k] && !cols[k[1:0]]) rows[k[3:2]] = 1'b0;
    end
    return rows;
  endfunction

  assign row_in = rows_for(pressed, col_out);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (key_valid_out) begin
      pulse_cnt++;
      chk("pulse_width_prev_low", 32'(prev_valid), 32'd0);
    end
    prev_valid = key_valid_out;
  end

  function automatic logic [3:0] code_of(input logic [15:0] m);
    logic [3:0] grid [16];
    grid = '{4'h1, 4'h2, 4'h3, 4'hA,
             4'h4, 4'h5, 4'h6, 4'hB,
             4'h7, 4'h8, 4'h9, 4'hC,
             4'h0, 4'hF, 4'hE, 4'hD};
    for (int i = 0; i < 16; i++) begin
      if (m == (16'h1 << i)) return grid[4'(i)];
    end
    return 4'h0;
  endfunction

  task automatic model_reset();
    hist = {};
    hist.push_back(16'h0);
    m_keys = '0;
    m_code = '0;
    m_held = 1'b0;
  endtask

  // Debounced map follows a snapshot once DS+1 consecutive history entries agree.
  task automatic model_scan(input logic [15:0] snap);
    logic [15:0] old;
    logic        same;
    old = m_keys;
    hist.push_back(snap);
    if (hist.size() > DS + 1) void'(hist.pop_front());
    same = (hist.size() == DS + 1);
    foreach (hist[i]) if (hist[i] != snap) same = 1'b0;
    if (same) m_keys = snap;
    if ($countones(m_keys) == 1 && $countones(old) == 0) begin
      m_pulses++;
      m_code = code_of(m_keys);
    end
    m_held = ($countones(m_keys) == 1);
  endtask

  // Called right after a scan-completion edge; returns right after the next one.
  task automatic do_scan(input logic [15:0] p);
    pressed = p;
    repeat (SCAN_CYC - 1) @(posedge clk_in);
    #1;
    chk("code_mid", 32'(key_code_out), 32'(m_code));
    chk("held_mid", 32'(key_held_out), 32'(m_held));
    chk("pulses_mid", 32'(pulse_cnt), 32'(m_pulses));
    @(posedge clk_in);
    #1;
    model_scan(p);
    chk("keys_scan", 32'(keys_out), 32'(m_keys));
  endtask

  function automatic vec_t mk(input logic [15:0] press, input int scans, input logic [15:0] keys,
                              input logic [3:0] code, input logic held, input int pulses);
    vec_t v;
    v.press = press; v.scans = scans; v.keys = keys;
    v.code = code; v.held = held; v.pulses = pulses;
    return v;
  endfunction

  initial begin
    vecs[0]  = mk(16'h0000, 2, 16'h0000, 4'h0, 1'b0, 0);
    vecs[1]  = mk(16'h0020, 8, 16'h0020, 4'h5, 1'b1, 1);
    vecs[2]  = mk(16'h0000, 4, 16'h0000, 4'h5, 1'b0, 1);
    vecs[3]  = mk(16'h4000, 1, 16'h0000, 4'h5, 1'b0, 1);
    vecs[4]  = mk(16'h0000, 1, 16'h0000, 4'h5, 1'b0, 1);
    vecs[5]  = mk(16'h4000, 1, 16'h0000, 4'h5, 1'b0, 1);
    vecs[6]  = mk(16'h0000, 3, 16'h0000, 4'h5, 1'b0, 1);
    vecs[7]  = mk(16'h0801, 6, 16'h0801, 4'h5, 1'b0, 1);
    vecs[8]  = mk(16'h0000, 4, 16'h0000, 4'h5, 1'b0, 1);
    vecs[9]  = mk(16'h0008, 4, 16'h0008, 4'hA, 1'b1, 2);
    vecs[10] = mk(16'h1008, 4, 16'h1008, 4'hA, 1'b0, 2);
    vecs[11] = mk(16'h1000, 4, 16'h1000, 4'hA, 1'b1, 2);
    vecs[12] = mk(16'h0000, 4, 16'h0000, 4'hA, 1'b0, 2);

    rst_in = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_col", 32'(col_out), 32'(4'b1111));
    chk("rst_keys", 32'(keys_out), 32'd0);
    chk("rst_valid", 32'(key_valid_out), 32'd0);
    chk("rst_code", 32'(key_code_out), 32'd0);
    chk("rst_held", 32'(key_held_out), 32'd0);
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(posedge clk_in);
    #1;
    chk("col_first", 32'(col_out), 32'(4'b1110));
    model_reset();
    fork
      begin
        repeat (SP) @(posedge clk_in);
        #1 chk("col_1", 32'(col_out), 32'(4'b1101));
        repeat (SP) @(posedge clk_in);
        #1 chk("col_2", 32'(col_out), 32'(4'b1011));
        repeat (SP) @(posedge clk_in);
        #1 chk("col_3", 32'(col_out), 32'(4'b0111));
        repeat (SP) @(posedge clk_in);
        #1 chk("col_wrap", 32'(col_out), 32'(4'b1110));
      end
    join_none

    for (int i = 0; i < NV; i++) begin
      repeat (vecs[i].scans) do_scan(vecs[i].press);
      row_sel = i;
      fork
        begin
          @(posedge clk_in);
          #1;
          chk($sformatf("row%0d_keys", row_sel), 32'(keys_out), 32'(vecs[row_sel].keys));
          chk($sformatf("row%0d_code", row_sel), 32'(key_code_out), 32'(vecs[row_sel].code));
          chk($sformatf("row%0d_held", row_sel), 32'(key_held_out), 32'(vecs[row_sel].held));
          chk($sformatf("row%0d_pulses", row_sel), 32'(pulse_cnt), 32'(vecs[row_sel].pulses));
        end
      join_none
    end

    for (int s = 0; s < 25; s++) begin
      logic [15:0] p;
      int unsigned kind;
      int unsigned hold;
      kind = $urandom_range(0, 3);
      p = '0;
      if (kind == 1 || kind == 2) p = 16'h1 << $urandom_range(0, 15);
      else if (kind == 3) p = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      hold = $urandom_range(1, 4);
      repeat (hold) do_scan(p);
    end

    repeat (DS + 1) do_scan(16'h0);
    do_scan(16'h0200);
    rst_in = 1'b1;
    @(posedge clk_in);
    @(posedge clk_in);
    @(negedge clk_in);
    chk("mid_rst_col", 32'(col_out), 32'(4'b1111));
    chk("mid_rst_keys", 32'(keys_out), 32'd0);
    chk("mid_rst_code", 32'(key_code_out), 32'd0);
    chk("mid_rst_held", 32'(key_held_out), 32'd0);
    chk("mid_rst_valid", 32'(key_valid_out), 32'd0);
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(posedge clk_in);
    #1;
    chk("mid_rst_col0", 32'(col_out), 32'(4'b1110));
    model_reset();
    repeat (3) do_scan(16'h0200);
    @(negedge clk_in);
    chk("mid_pulse_early", 32'(key_valid_out), 32'd0);
    @(negedge clk_in);
    chk("mid_pulse", 32'(key_valid_out), 32'd1);
    chk("mid_pulse_code", 32'(key_code_out), 32'h8);
    repeat (3) @(posedge clk_in);
    #1;
    chk("mid_code_hold", 32'(key_code_out), 32'h8);
    chk("mid_held", 32'(key_held_out), 32'd1);
    chk("mid_keys", 32'(keys_out), 32'h0200);
    chk("mid_pulses", 32'(pulse_cnt), 32'(m_pulses));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
